fir_requant_buffer: RTL and testbench
=====================================

// Module: fir_requant_buffer
// PURPOSE
// - Stage directly downstream of the FIR filter.
// - Rounds, shifts and saturates the 48-bit unsigned FIR sum to OUT_WIDTH bits, then decimates by a runtime factor.
// - Buffers kept samples in a FIFO sized to absorb the FIR pipeline still in flight after this block drops tready.
// - Carries the laser-lost flag through the same path.
// PARAMETERS
// TCQ           0.1  simulation clock-to-q delay on all registered assignments
// IN_WIDTH      48   FIR output width (tap width 32 + data width 16)
// OUT_WIDTH     16   output sample width
// FIFO_DEPTH    64   buffer entries, power of two
// AFULL_MARGIN  32   free slots reserved for in-flight beats; must be >= FIR latency + 4
// PORTS
// clk_i           in   1          single clock
// rst_i           in   1          asynchronous reset, active-high
// cfg_load_i      in   1          one-cycle pulse: latch shift_i and decim_factor_i
// shift_i         in   6          right-shift amount, 0..IN_WIDTH-1
// decim_factor_i  in   8          keep 1 of N beats; 0 is treated as 1
// s_axis_tdata_i  in   IN_WIDTH   FIR sum, unsigned
// s_axis_tvalid_i in   1          FIR beat valid
// s_axis_lost_i   in   1          laser-lost flag aligned with the beat
// s_axis_tready_o out  1          credit to FIR; low = stop issuing
// m_axis_tdata_o  out  OUT_WIDTH  requantised sample
// m_axis_tlost_o  out  1          OR of lost flags over the decimation window
// m_axis_tvalid_o out  1          output valid
// m_axis_tready_i in   1          downstream ready
// sat_cnt_o       out  16         count of saturated kept samples; holds at 0xFFFF
// overflow_o      out  1          sticky: a beat arrived while the FIFO was full
// BEHAVIOUR
// - Reset (async, any time):
//   - Outputs: tvalid=0, tdata=0, tlost=0, tready=0, sat_cnt=0, overflow=0.
//   - Internal: FIFO empty; pipeline cleared; shift=0; decim=1; phase=0.
//   - First cycle after release: s_axis_tready_o rises to 1.
// - Input acceptance:
//   - Every s_axis_tvalid_i beat is taken, whatever the state of tready.
//   - FIR keeps delivering in-flight beats after tready falls.
// - Stage 1 (t+1): r = in + (shift==0 ? 0 : 1<<(shift-1)), computed in IN_WIDTH+1 bits with no wrap.
// - Stage 2 (t+2):
//   - q = r >> shift.
//   - If q > 2^OUT_WIDTH-1: q = 2^OUT_WIDTH-1, sat flag set.
//   - Decimation:
//     - phase counts 0..N-1 on each stage-2 beat; the beat is kept when phase==N-1.
//     - The lost accumulator ORs every beat in the window and clears after each kept beat.
//     - A kept beat writes {lost_acc|lost, q} to the FIFO.
//     - sat_cnt increments on kept beats with the sat flag set.
// - FIFO output:
//   - FWFT registered output; tvalid rises at t+3 when the FIFO is empty and N=1.
//   - tdata and tlost hold stable while tvalid=1 and tready_i=0.
//   - Simultaneous write and read at any fill level: count is unchanged, no loss.
// - s_axis_tready_o is registered.
//   - Low when count >= FIFO_DEPTH-AFULL_MARGIN.
//   - High again when count < FIFO_DEPTH-AFULL_MARGIN.
// - FIFO full and a write with no read in the same cycle: the beat is dropped and overflow_o is set.
//   - overflow_o clears only on reset.
// - cfg_load_i:
//   - Latches shift and decim.
//   - Clears phase, the lost accumulator and sat_cnt.
//   - Beats already in stages 1-2 finish with the old settings.
//   - The FIFO contents are kept.
// TESTING
// - rst release, shift=0, N=1, beats 5, 0x1_0000, 0xFFFF -> out 5, 0xFFFF (sat), 0xFFFF; sat_cnt=1; first tvalid at t+3.
// - shift=32, in=0x0000_8000_0000 -> 1 (round half up); in=0x0000_7FFF_FFFF -> 0.
// - N=4, 8 beats 1..8, lost on beat 2 -> out 4 (lost=1), 8 (lost=0).
// - tready_i=0, 40 continuous beats -> s_axis_tready_o low once count reaches 32; all 40 stored; overflow_o=0; drain order intact.
// - tready_i=0, 70 beats ignoring tready -> 64 stored, overflow_o=1; rst mid-stream -> FIFO empty, outputs 0.
// - cfg_load_i with N=3 at phase 1 -> phase restarts; the next kept beat is the 3rd beat after the load.

Source files
------------

// File: rtl/fir_requant_buffer_if.sv
// Valid/ready stream with a side-band lost flag, used for both the FIR-facing and the
// downstream-facing ports of the requantiser.
interface fir_requant_buffer_if #(
  parameter int unsigned Width = 16
);
  logic [Width-1:0] tdata;
  logic             tvalid;
  logic             tlost;
  logic             tready;

  modport master (output tdata, tvalid, tlost, input tready);
  modport slave  (input tdata, tvalid, tlost, output tready);
endinterface

// File: rtl/fir_requant_buffer.sv
// Round/shift/saturate of the FIR sum, runtime decimation, and an FWFT buffer whose tready
// credit leaves headroom for beats still in flight inside the FIR.
module fir_requant_buffer #(
  parameter int unsigned IN_WIDTH     = 48,
  parameter int unsigned OUT_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned AFULL_MARGIN = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_load_i,
  input  logic [5:0]             shift_i,
  input  logic [7:0]             decim_factor_i,
  fir_requant_buffer_if.slave    s_axis,
  fir_requant_buffer_if.master   m_axis,
  output logic [15:0]            sat_cnt_o,
  output logic                   overflow_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [IN_WIDTH:0] RoundOne = {{IN_WIDTH{1'b0}}, 1'b1};

  // Configuration
  logic [5:0] shift_q;
  logic [7:0] decim_q;

  // Stage 1: rounded sum, with the shift it was rounded for
  logic                s1_valid_q;
  logic [IN_WIDTH:0]   s1_sum_q;
  logic                s1_lost_q;
  logic [5:0]          s1_shift_q;
  logic [IN_WIDTH:0]   round_add;

  // Stage 2: decimated, saturated sample
  logic [IN_WIDTH:0]   shifted;
  logic                sat;
  logic [OUT_WIDTH-1:0] q;
  logic                keep;
  logic [7:0]          phase_q;
  logic                lost_acc_q;
  logic [15:0]         sat_cnt_q;
  logic                s2_valid_q;
  logic [OUT_WIDTH:0]  s2_data_q;

  // Buffer: memory plus a registered head; occupancy counts both
  logic [OUT_WIDTH:0]  mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     mem_cnt_q, mem_cnt_d, occ;
  logic                out_valid_q;
  logic [OUT_WIDTH:0]  out_data_q;
  logic                tready_q;
  logic                overflow_q;
  logic                pop, full, wr_ok, slot_free, load_mem, bypass, push;

  always_comb begin
    round_add = '0;
    if (shift_q != 6'd0) round_add = RoundOne << (shift_q - 6'd1);
  end

  always_comb begin
    shifted = s1_sum_q >> s1_shift_q;
    sat     = |shifted[IN_WIDTH:OUT_WIDTH];
    q       = sat ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
    keep    = s1_valid_q && (phase_q == decim_q - 8'd1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q    <= '0;
      decim_q    <= 8'd1;
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_lost_q  <= 1'b0;
      s1_shift_q <= '0;
    end else begin
      if (cfg_load_i) begin
        shift_q <= shift_i;
        decim_q <= (decim_factor_i == 8'd0) ? 8'd1 : decim_factor_i;
      end
      s1_valid_q <= s_axis.tvalid;
      s1_sum_q   <= {1'b0, s_axis.tdata} + round_add;
      s1_lost_q  <= s_axis.tlost;
      s1_shift_q <= shift_q;
    end
  end

  // A load restarts the decimation window even if a beat is leaving stage 1 this cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q    <= '0;
      lost_acc_q <= 1'b0;
      sat_cnt_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s2_valid_q <= keep;
      s2_data_q  <= {lost_acc_q | s1_lost_q, q};
      if (cfg_load_i) begin
        phase_q    <= '0;
        lost_acc_q <= 1'b0;
        sat_cnt_q  <= '0;
      end else if (s1_valid_q) begin
        if (keep) begin
          phase_q    <= '0;
          lost_acc_q <= 1'b0;
          if (sat && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
        end else begin
          phase_q    <= phase_q + 8'd1;
          lost_acc_q <= lost_acc_q | s1_lost_q;
        end
      end
    end
  end

  always_comb begin
    pop       = out_valid_q & m_axis.tready;
    occ       = mem_cnt_q + {{(CntW-1){1'b0}}, out_valid_q};
    full      = (occ == CntW'(FIFO_DEPTH));
    wr_ok     = s2_valid_q & (~full | pop);
    slot_free = ~out_valid_q | pop;
    load_mem  = slot_free & (mem_cnt_q != '0);
    // Empty buffer: a new sample goes straight into the output register
    bypass    = slot_free & (mem_cnt_q == '0) & wr_ok;
    push      = wr_ok & ~bypass;
    mem_cnt_d = mem_cnt_q + CntW'(push) - CntW'(load_mem);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= s2_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      tready_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      tready_q  <= (occ < CntW'(FIFO_DEPTH - AFULL_MARGIN));
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (load_mem) begin
        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
        out_data_q <= mem[rd_ptr_q];
      end else if (bypass) begin
        out_data_q <= s2_data_q;
      end
      if (slot_free) out_valid_q <= load_mem | bypass;
      if (s2_valid_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q[OUT_WIDTH-1:0];
  assign m_axis.tlost  = out_data_q[OUT_WIDTH];
  assign s_axis.tready = tready_q;
  assign sat_cnt_o     = sat_cnt_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_fir_requant_buffer.sv
// Directed bench for fir_requant_buffer: a sequence-level model predicts every kept output,
// and one compare process checks each accepted output beat against it.
module tb_fir_requant_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [5:0]  shift;
  logic [7:0]  decim;
  logic [15:0] sat_cnt;
  logic        overflow;

  fir_requant_buffer_if #(.Width(48)) s_if ();
  fir_requant_buffer_if #(.Width(16)) m_if ();

  fir_requant_buffer #(
    .IN_WIDTH     (48),
    .OUT_WIDTH    (16),
    .FIFO_DEPTH   (64),
    .AFULL_MARGIN (32)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_load_i     (cfg_load),
    .shift_i        (shift),
    .decim_factor_i (decim),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .sat_cnt_o      (sat_cnt),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [16:0] exp_q [$];
  logic [16:0] obs [$];
  int          m_shift, m_n, m_phase, m_sat;
  logic        m_acc, m_ovf;

  function automatic logic [16:0] requant(input logic [47:0] d, input int sh);
    longint unsigned v;
    v = d;
    if (sh > 0) v = v + (64'd1 << (sh - 1));
    v = v >> sh;
    if (v > 64'd65535) return {1'b1, 16'hFFFF};
    return {1'b0, v[15:0]};
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    obs.delete();
    m_shift = 0; m_n = 1; m_phase = 0; m_sat = 0; m_acc = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic send(input logic [47:0] d, input logic lost);
    logic [16:0] r;
    @(posedge clk); #1;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlost = lost;
    r = requant(d, m_shift);
    m_acc = m_acc | lost;
    if (m_phase == m_n - 1) begin
      if (exp_q.size() < 64) exp_q.push_back({m_acc, r[15:0]});
      else m_ovf = 1'b1;
      if (r[16] && m_sat < 65535) m_sat++;
      m_phase = 0;
      m_acc = 1'b0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_if.tvalid = 1'b0; s_if.tlost = 1'b0;
  endtask

  task automatic cfg(input int sh, input int n);
    idle();
    repeat (4) @(posedge clk);
    #1;
    cfg_load = 1'b1; shift = 6'(sh); decim = 8'(n);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    m_shift = sh; m_n = (n == 0) ? 1 : n; m_phase = 0; m_acc = 1'b0; m_sat = 0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(name, 48'(exp_q.size()), 48'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Compare process: every beat accepted downstream must be the next predicted sample
  always @(negedge clk) begin
    if (!rst && m_if.tvalid && m_if.tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", {m_if.tlost, m_if.tdata});
      end else begin
        check("out_sample", 48'({m_if.tlost, m_if.tdata}), 48'(exp_q.pop_front()));
      end
      obs.push_back({m_if.tlost, m_if.tdata});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_load = 1'b0; shift = '0; decim = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlost = 1'b0;
    m_if.tready = 1'b1;
    model_reset();

    // Model pins
    check("model_round_up", 48'(requant(48'h0000_8000_0000, 32)), 48'h00001);
    check("model_round_dn", 48'(requant(48'h0000_7FFF_FFFF, 32)), 48'h00000);
    check("model_sat",      48'(requant(48'h0000_0001_0000, 0)),  48'h1FFFF);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 48'(m_if.tvalid), 48'd0);
    check("rst_tdata",  48'(m_if.tdata),  48'd0);
    check("rst_tlost",  48'(m_if.tlost),  48'd0);
    check("rst_tready", 48'(s_if.tready), 48'd0);
    check("rst_sat",    48'(sat_cnt),     48'd0);
    check("rst_ovf",    48'(overflow),    48'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rel_tready_c0", 48'(s_if.tready), 48'd0);
    @(negedge clk);
    check("rel_tready_c1", 48'(s_if.tready), 48'd1);

    // Latency, saturation, defaults shift=0 N=1
    send(48'h5, 1'b0);
    @(negedge clk); check("lat_c1", 48'(m_if.tvalid), 48'd0);
    send(48'h1_0000, 1'b0);
    @(negedge clk); check("lat_c2", 48'(m_if.tvalid), 48'd0);
    send(48'hFFFF, 1'b0);
    @(negedge clk); check("lat_c3", 48'(m_if.tvalid), 48'd0);
    idle();
    @(negedge clk); check("lat_c4", 48'(m_if.tvalid), 48'd1);
    wait_drain("t1_drain");
    check("t1_count", 48'(obs.size()), 48'd3);
    check("t1_o0", 48'(obs[0]), 48'h00005);
    check("t1_o1", 48'(obs[1]), 48'h0FFFF);
    check("t1_o2", 48'(obs[2]), 48'h0FFFF);
    check("t1_sat", 48'(sat_cnt), 48'd1);
    check("t1_sat_model", 48'(sat_cnt), 48'(m_sat));

    // Round half up at shift=32
    cfg(32, 1);
    obs.delete();
    send(48'h0000_8000_0000, 1'b0);
    send(48'h0000_7FFF_FFFF, 1'b0);
    idle();
    wait_drain("t2_drain");
    check("t2_count", 48'(obs.size()), 48'd2);
    check("t2_o0", 48'(obs[0]), 48'h00001);
    check("t2_o1", 48'(obs[1]), 48'h00000);
    check("t2_sat", 48'(sat_cnt), 48'd0);

    // Decimate by 4 with a lost flag in the first window
    cfg(0, 4);
    obs.delete();
    for (int i = 1; i <= 8; i++) send(48'(i), (i == 2));
    idle();
    wait_drain("t3_drain");
    check("t3_count", 48'(obs.size()), 48'd2);
    check("t3_o0", 48'(obs[0]), 48'h10004);
    check("t3_o1", 48'(obs[1]), 48'h00008);

    // Backpressure: 40 beats stored, then drain while writing
    cfg(0, 1);
    obs.delete();
    m_if.tready = 1'b0;
    for (int i = 0; i < 40; i++) send(48'(16'h100 + i), 1'b0);
    idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t4_tready_low", 48'(s_if.tready), 48'd0);
    check("t4_ovf", 48'(overflow), 48'd0);
    check("t4_tvalid", 48'(m_if.tvalid), 48'd1);
    m_if.tready = 1'b1;
    for (int i = 40; i < 50; i++) send(48'(16'h100 + i), 1'b0);
    idle();
    wait_drain("t4_drain");
    check("t4_count", 48'(obs.size()), 48'd50);
    check("t4_first", 48'(obs[0]), 48'h00100);
    check("t4_o39", 48'(obs[39]), 48'h00127);
    check("t4_last", 48'(obs[49]), 48'h00131);
    check("t4_tready_high", 48'(s_if.tready), 48'd1);
    check("t4_ovf_end", 48'(overflow), 48'd0);

    // Overflow: 70 beats into a stalled output, then asynchronous reset mid-stream
    obs.delete();
    m_if.tready = 1'b0;
    for (int i = 0; i < 70; i++) send(48'(16'h200 + i), 1'b0);
    idle();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t5_ovf", 48'(overflow), 48'(m_ovf));
    check("t5_ovf_lit", 48'(overflow), 48'd1);
    check("t5_model_fill", 48'(exp_q.size()), 48'd64);
    check("t5_head", 48'(m_if.tdata), 48'h0200);
    for (int i = 0; i < 3; i++) send(48'h300, 1'b0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("t5_rst_tvalid", 48'(m_if.tvalid), 48'd0);
    check("t5_rst_tdata",  48'(m_if.tdata),  48'd0);
    check("t5_rst_tready", 48'(s_if.tready), 48'd0);
    check("t5_rst_ovf",    48'(overflow),    48'd0);
    check("t5_rst_sat",    48'(sat_cnt),     48'd0);
    s_if.tvalid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_if.tready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t5_post_tvalid", 48'(m_if.tvalid), 48'd0);
    check("t5_post_obs", 48'(obs.size()), 48'd0);
    check("t5_post_tready", 48'(s_if.tready), 48'd1);

    // Load mid-window restarts the phase
    cfg(0, 3);
    send(48'd99, 1'b0);
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("t6_none_before", 48'(obs.size()), 48'd0);
    cfg(0, 3);
    send(48'd10, 1'b0);
    send(48'd20, 1'b0);
    send(48'd30, 1'b0);
    idle();
    wait_drain("t6_drain");
    check("t6_count", 48'(obs.size()), 48'd1);
    check("t6_o0", 48'(obs[0]), 48'h0001E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
